// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order types: ROB tag width, multiply opcodes and the
// structs passed between dispatch, the multiply station and the CDB.
package rv32i_types;

  localparam int ROB_TAG_W = 4;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef enum logic [1:0] {
    reg_mul   = 2'd0,
    reg_mulh  = 2'd1,
    reg_mulsu = 2'd2,
    reg_mulhu = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } issue_state_t;

  typedef struct packed {
    mul_op_t     operation;
    rob_tag_t    q1_tag;
    logic        q1_valid;
    logic [31:0] q1_data;
    rob_tag_t    q2_tag;
    logic        q2_valid;
    logic [31:0] q2_data;
    rob_tag_t    rob_dest;
  } rs_mul_dispatch_t;

  typedef struct packed {
    mul_op_t     operation;
    logic [31:0] q1_data;
    logic [31:0] q2_data;
    rob_tag_t    rob_dest;
  } rs_mul_output_t;

  typedef struct packed {
    rob_tag_t    rob_entry;
    logic [31:0] rd_data;
  } cdb_t;

endpackage

// File: rtl/rs_priority_picker.sv
// Lowest-index-set-bit encoder; used for both free-slot and ready-slot selection.
module rs_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scanning downward lets the lowest set bit be the last (winning) assignment.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rs_mul_station.sv
// Multiply reservation station: holds dispatched multiplies, snoops the CDB for
// missing operands and issues one ready entry at a time to the multiplier.
module rs_mul_station
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispatch_valid,
  input  rs_mul_dispatch_t dispatch,
  output logic             rs_full,
  input  logic             cdb_valid,
  input  cdb_t             cdb,
  input  logic             mul_ready,
  input  logic             mul_done,
  output logic             mul_start,
  output rs_mul_output_t   mul_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] valid;
  rs_mul_dispatch_t ent [DEPTH];
  logic [DEPTH-1:0] ready_vec;
  rs_mul_dispatch_t disp_in;

  issue_state_t     state, state_next;
  logic [IDX_W-1:0] issue_idx;

  logic             free_found, rdy_found;
  logic [IDX_W-1:0] free_idx, rdy_idx;
  logic             dispatch_fire, issue_latch, release_fire;

  assign rs_full       = &valid;
  assign dispatch_fire = dispatch_valid & ~rs_full & free_found;
  assign issue_latch   = (state == IDLE) & mul_ready & rdy_found;
  assign release_fire  = (state == BUSY) & mul_done;

  // The in-flight entry stays valid through BUSY, so it is masked out explicitly.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid[i] & ent[i].q1_valid & ent[i].q2_valid
                     & ~((state != IDLE) && (issue_idx == IDX_W'(i)));
    end
  end

  rs_priority_picker #(.N(DEPTH)) u_free_pick (
    .req   (~valid),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_priority_picker #(.N(DEPTH)) u_ready_pick (
    .req   (ready_vec),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  // Same-cycle CDB bypass so a dispatch never misses a broadcast it raced with.
  always_comb begin
    disp_in = dispatch;
    if (cdb_valid && !dispatch.q1_valid && dispatch.q1_tag == cdb.rob_entry) begin
      disp_in.q1_valid = 1'b1;
      disp_in.q1_data  = cdb.rd_data;
    end
    if (cdb_valid && !dispatch.q2_valid && dispatch.q2_tag == cdb.rob_entry) begin
      disp_in.q2_valid = 1'b1;
      disp_in.q2_data  = cdb.rd_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue_latch) state_next = BUSY;
      BUSY:    if (mul_done)    state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Dispatch and release always target different slots, so both may land together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      issue_idx <= '0;
      valid     <= '0;
    end else begin
      state <= state_next;
      if (issue_latch)   issue_idx <= rdy_idx;
      if (dispatch_fire) valid[free_idx] <= 1'b1;
      if (release_fire)  valid[issue_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (dispatch_fire && free_idx == IDX_W'(i)) begin
        ent[i] <= disp_in;
      end else if (valid[i] && cdb_valid) begin
        if (!ent[i].q1_valid && ent[i].q1_tag == cdb.rob_entry) begin
          ent[i].q1_valid <= 1'b1;
          ent[i].q1_data  <= cdb.rd_data;
        end
        if (!ent[i].q2_valid && ent[i].q2_tag == cdb.rob_entry) begin
          ent[i].q2_valid <= 1'b1;
          ent[i].q2_data  <= cdb.rd_data;
        end
      end
    end
  end

  always_comb begin
    mul_start = (state == BUSY);
    mul_data  = '0;
    if (state == BUSY) begin
      mul_data.operation = ent[issue_idx].operation;
      mul_data.q1_data   = ent[issue_idx].q1_data;
      mul_data.q2_data   = ent[issue_idx].q2_data;
      mul_data.rob_dest  = ent[issue_idx].rob_dest;
    end
  end

endmodule

// File: tb/tb_rs_mul_station.sv
// Directed bench for rs_mul_station: issue handshake, CDB capture and bypass,
// full/drop behaviour, lowest-index priority and asynchronous reset.
module tb_rs_mul_station;
  import rv32i_types::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             dispatch_valid;
  rs_mul_dispatch_t dispatch;
  logic             rs_full;
  logic             cdb_valid;
  cdb_t             cdb;
  logic             mul_ready;
  logic             mul_done;
  logic             mul_start;
  rs_mul_output_t   mul_data;

  int vectors    = 0;
  int miscompares = 0;

  rs_mul_station #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .dispatch_valid (dispatch_valid),
    .dispatch       (dispatch),
    .rs_full        (rs_full),
    .cdb_valid      (cdb_valid),
    .cdb            (cdb),
    .mul_ready      (mul_ready),
    .mul_done       (mul_done),
    .mul_start      (mul_start),
    .mul_data       (mul_data)
  );

  always #5 clk = ~clk;

  function automatic rs_mul_dispatch_t mk_disp(mul_op_t op,
      logic q1v, logic [3:0] q1t, logic [31:0] q1d,
      logic q2v, logic [3:0] q2t, logic [31:0] q2d, logic [3:0] dest);
    rs_mul_dispatch_t d;
    d.operation = op;
    d.q1_valid  = q1v;
    d.q1_tag    = q1t;
    d.q1_data   = q1d;
    d.q2_valid  = q2v;
    d.q2_tag    = q2t;
    d.q2_data   = q2d;
    d.rob_dest  = dest;
    return d;
  endfunction

  function automatic rs_mul_output_t mk_out(mul_op_t op, logic [31:0] a,
      logic [31:0] b, logic [3:0] dest);
    rs_mul_output_t o;
    o.operation = op;
    o.q1_data   = a;
    o.q2_data   = b;
    o.rob_dest  = dest;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input rs_mul_output_t obs,
      input rs_mul_output_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered while IDLE with the expected entry ready; leaves the FSM back in IDLE.
  task automatic expect_issue(input string tag, input rs_mul_output_t exp);
    tick();
    check_bit({tag, "_start"}, mul_start, 1'b1);
    check_data({tag, "_data"}, mul_data, exp);
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    check_bit({tag, "_release"}, mul_start, 1'b0);
    tick();
    check_bit({tag, "_idle"}, mul_start, 1'b0);
  endtask

  rs_mul_output_t exp_out;

  initial begin
    rst            = 1'b1;
    dispatch_valid = 1'b0;
    dispatch       = '0;
    cdb_valid      = 1'b0;
    cdb            = '0;
    mul_ready      = 1'b0;
    mul_done       = 1'b0;
    tick();
    tick();
    check_bit("reset_start", mul_start, 1'b0);
    check_bit("reset_full", rs_full, 1'b0);
    check_data("reset_data", mul_data, '0);
    rst = 1'b0;
    tick();

    // Both operands ready: issue follows the cycle the entry becomes ready.
    mul_ready      = 1'b1;
    dispatch_valid = 1'b1;
    dispatch       = mk_disp(reg_mul, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd5, 4'd2);
    tick();
    dispatch_valid = 1'b0;
    check_bit("basic_pre_issue", mul_start, 1'b0);
    exp_out = mk_out(reg_mul, 32'd3, 32'd5, 4'd2);
    tick();
    check_bit("basic_start", mul_start, 1'b1);
    check_data("basic_data", mul_data, exp_out);
    tick();
    check_data("basic_hold1", mul_data, exp_out);
    tick();
    check_bit("basic_hold_start", mul_start, 1'b1);
    check_data("basic_hold2", mul_data, exp_out);
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    check_bit("basic_release", mul_start, 1'b0);
    check_data("basic_release_data", mul_data, '0);
    tick();
    check_bit("basic_idle", mul_start, 1'b0);

    // q2 waits on tag 7 until the CDB supplies it.
    dispatch_valid = 1'b1;
    dispatch       = mk_disp(reg_mulh, 1'b1, 4'd0, 32'd6, 1'b0, 4'd7, 32'd0, 4'd1);
    tick();
    dispatch_valid = 1'b0;
    tick();
    check_bit("wait_no_issue1", mul_start, 1'b0);
    tick();
    check_bit("wait_no_issue2", mul_start, 1'b0);
    cdb_valid = 1'b1;
    cdb.rob_entry = 4'd7;
    cdb.rd_data   = 32'hFFFF_FFFF;
    tick();
    cdb_valid = 1'b0;
    check_bit("wait_capture_edge", mul_start, 1'b0);
    expect_issue("wait", mk_out(reg_mulh, 32'd6, 32'hFFFF_FFFF, 4'd1));

    // Dispatch racing a CDB broadcast for its q1 tag.
    dispatch_valid = 1'b1;
    dispatch       = mk_disp(reg_mulhu, 1'b0, 4'd4, 32'd0, 1'b1, 4'd0, 32'd2, 4'd3);
    cdb_valid      = 1'b1;
    cdb.rob_entry  = 4'd4;
    cdb.rd_data    = 32'd9;
    tick();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    check_bit("bypass_pre_issue", mul_start, 1'b0);
    expect_issue("bypass", mk_out(reg_mulhu, 32'd9, 32'd2, 4'd3));

    // Fill all four slots with the multiplier stalled, then offer a fifth.
    mul_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dispatch_valid = 1'b1;
      dispatch = mk_disp(reg_mul, 1'b1, 4'd0, 32'(i + 1), 1'b1, 4'd0, 32'(10 + i), 4'(i + 8));
      tick();
      check_bit($sformatf("fill_full_%0d", i), rs_full, (i == 3));
    end
    dispatch = mk_disp(reg_mulh, 1'b1, 4'd0, 32'hAA, 1'b1, 4'd0, 32'hBB, 4'd15);
    tick();
    dispatch_valid = 1'b0;
    check_bit("fill_drop_full", rs_full, 1'b1);
    mul_ready = 1'b1;
    tick();
    check_bit("fill_e0_start", mul_start, 1'b1);
    check_data("fill_e0_data", mul_data, mk_out(reg_mul, 32'd1, 32'd10, 4'd8));
    check_bit("fill_busy_full", rs_full, 1'b1);
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    check_bit("fill_freed", rs_full, 1'b0);
    check_bit("fill_release", mul_start, 1'b0);
    tick();
    check_bit("fill_idle", mul_start, 1'b0);
    expect_issue("fill_e1", mk_out(reg_mul, 32'd2, 32'd11, 4'd9));
    expect_issue("fill_e2", mk_out(reg_mul, 32'd3, 32'd12, 4'd10));
    expect_issue("fill_e3", mk_out(reg_mul, 32'd4, 32'd13, 4'd11));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit($sformatf("fill_no_fifth_%0d", i), mul_start, 1'b0);
    end

    // Slots 1 and 3 become ready together; 0 and 2 wait on a tag never broadcast.
    mul_ready      = 1'b0;
    dispatch_valid = 1'b1;
    dispatch = mk_disp(reg_mul, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'h20, 4'd4);
    tick();
    dispatch = mk_disp(reg_mulsu, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'h21, 4'd5);
    tick();
    dispatch = mk_disp(reg_mul, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'h22, 4'd6);
    tick();
    dispatch = mk_disp(reg_mul, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'h23, 4'd7);
    tick();
    dispatch_valid = 1'b0;
    check_bit("prio_full", rs_full, 1'b1);
    cdb_valid     = 1'b1;
    cdb.rob_entry = 4'd6;
    cdb.rd_data   = 32'h11;
    tick();
    cdb_valid = 1'b0;
    mul_ready = 1'b1;
    expect_issue("prio_e1", mk_out(reg_mulsu, 32'h11, 32'h21, 4'd5));
    expect_issue("prio_e3", mk_out(reg_mul, 32'h11, 32'h23, 4'd7));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit($sformatf("prio_no_dup_%0d", i), mul_start, 1'b0);
    end

    // Refill slots 1 and 3, start an issue, then reset between clock edges.
    mul_ready      = 1'b0;
    dispatch_valid = 1'b1;
    dispatch = mk_disp(reg_mul, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'd8, 4'd12);
    tick();
    dispatch = mk_disp(reg_mulh, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 32'd10, 4'd13);
    tick();
    dispatch_valid = 1'b0;
    check_bit("rst_pre_full", rs_full, 1'b1);
    mul_ready = 1'b1;
    tick();
    check_bit("rst_pre_start", mul_start, 1'b1);
    check_data("rst_pre_data", mul_data, mk_out(reg_mul, 32'd7, 32'd8, 4'd12));
    #2;
    rst = 1'b1;
    #1;
    check_bit("rst_async_start", mul_start, 1'b0);
    check_bit("rst_async_full", rs_full, 1'b0);
    check_data("rst_async_data", mul_data, '0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit($sformatf("rst_abandon_%0d", i), mul_start, 1'b0);
    end
    check_bit("rst_after_full", rs_full, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
